// File: rtl/qosc_pkg.sv
// Shared types and encodings for the quadrature oscillator configuration loader.
package qosc_pkg;

  // 8-bit signed sample shared with quadrature_oscillator_sync.
  typedef logic signed [7:0] sample_t;

  localparam int unsigned NumRegs = 5;

  // Register bank indexed by address; entry 0 sits in the low byte.
  typedef sample_t [NumRegs-1:0] bank_t;

  // Header opcodes (header byte bits [7:5]); 110 and 111 are illegal.
  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_WRITE   = 3'd1;
  localparam logic [2:0] OP_COMMIT  = 3'd2;
  localparam logic [2:0] OP_START   = 3'd3;
  localparam logic [2:0] OP_HALT    = 3'd4;
  localparam logic [2:0] OP_CLR_ERR = 3'd5;

  // Register addresses (header byte bits [2:0]); 5-7 are reserved.
  localparam logic [2:0] ADDR_RE      = 3'd0;
  localparam logic [2:0] ADDR_IM      = 3'd1;
  localparam logic [2:0] ADDR_POWER   = 3'd2;
  localparam logic [2:0] ADDR_RE_INIT = 3'd3;
  localparam logic [2:0] ADDR_IM_INIT = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StLoad
  } state_e;

endpackage

// File: rtl/qosc_config_loader.sv
// Byte-stream command parser driving the oscillator's coefficients, preload values and load
// strobe. Writes land in a shadow bank; COMMIT/START copy the whole bank to the outputs at once.
module qosc_config_loader
  import qosc_pkg::*;
#(
  parameter sample_t     DEF_RE      = 8'sd126,
  parameter sample_t     DEF_IM      = 8'sd16,
  parameter sample_t     DEF_POWER   = 8'sd64,
  parameter sample_t     DEF_RE_INIT = 8'sd64,
  parameter sample_t     DEF_IM_INIT = 8'sd0,
  parameter int unsigned LOAD_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output sample_t    re_coeff,
  output sample_t    im_coeff,
  output sample_t    power,
  output sample_t    accu_re_init,
  output sample_t    accu_im_init,
  output logic       load,
  output logic       running,
  output logic       err
);

  // One counter serves both the DATA timeout and the LOAD pulse length.
  localparam int unsigned CntMax = (TIMEOUT > LOAD_CYCLES) ? TIMEOUT : LOAD_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam bank_t DefBank = {DEF_IM_INIT, DEF_RE_INIT, DEF_POWER, DEF_IM, DEF_RE};

  state_e          state_q, state_d;
  logic [2:0]      addr_q, addr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  bank_t           shadow_q, shadow_d;
  bank_t           active_q, active_d;
  logic            load_q, load_d;
  logic            running_q, running_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;

  logic            accept;
  logic [2:0]      hdr_op;
  logic [2:0]      hdr_addr;
  logic [CntW-1:0] cnt_inc;
  logic            unused_hdr_bits;

  assign accept          = in_valid & ready_q;
  assign hdr_op          = in_data[7:5];
  assign hdr_addr        = in_data[2:0];
  assign cnt_inc         = cnt_q + CntW'(1);
  assign unused_hdr_bits = ^in_data[4:3];

  // Next-state decode: header parsing in IDLE, data capture/timeout in DATA, pulse in LOAD.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    load_d    = load_q;
    running_d = running_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (hdr_op)
            OP_NOP: ;
            OP_WRITE: begin
              state_d = StData;
              addr_d  = hdr_addr;
              cnt_d   = '0;
            end
            OP_COMMIT: active_d = shadow_q;
            OP_START: begin
              active_d  = shadow_q;
              state_d   = StLoad;
              cnt_d     = CntW'(LOAD_CYCLES);
              load_d    = 1'b1;
              running_d = 1'b0;
            end
            OP_HALT: begin
              load_d    = 1'b1;
              running_d = 1'b0;
            end
            OP_CLR_ERR: err_d = 1'b0;
            default:    err_d = 1'b1;
          endcase
        end
      end
      StData: begin
        if (accept) begin
          // Reserved addresses still consume the byte so the stream stays framed.
          if (addr_q <= ADDR_IM_INIT) begin
            shadow_d[addr_q] = in_data;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntW'(TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StLoad: begin
        if (cnt_q <= CntW'(1)) begin
          state_d   = StIdle;
          load_d    = 1'b0;
          running_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d != StLoad);
  end

  // State and register bank; reset aborts any frame or load sequence without committing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      cnt_q     <= '0;
      shadow_q  <= DefBank;
      active_q  <= DefBank;
      load_q    <= 1'b1;
      running_q <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      load_q    <= load_d;
      running_q <= running_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  assign in_ready     = ready_q;
  assign re_coeff     = active_q[ADDR_RE];
  assign im_coeff     = active_q[ADDR_IM];
  assign power        = active_q[ADDR_POWER];
  assign accu_re_init = active_q[ADDR_RE_INIT];
  assign accu_im_init = active_q[ADDR_IM_INIT];
  assign load         = load_q;
  assign running      = running_q;
  assign err          = err_q;

endmodule
